mips_multicycle_controller: RTL and testbench
=============================================

Name: mips_multicycle_controller

Overview:
Moore-style FSM that sequences a multi-cycle MIPS datapath: one shared memory, IR/MDR/A/B/ALUOut holding registers, and one ALU. Decodes opcode/func from the IR and drives every datapath enable and mux select each cycle. Adds a memory-ready handshake so a slow memory can stall any memory-access state.

Parameters:
None. All encodings are fixed in the shared package.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
opcode  in  6  IR[31:26]
func  in  6  IR[5:0]
zero  in  1  ALU zero flag
memReady  in  1  memory completes the current access this cycle
pcLd  out  1  PC load enable (already qualified with zero for beq)
iOrD  out  1  memory address select: 0 = PC, 1 = ALUOut
memRead  out  1  memory read strobe
memWrite  out  1  memory write strobe
irWrite  out  1  IR load enable
aluSrcA  out  1  ALU input A select: 0 = PC, 1 = A
aluSrcB  out  2  ALU input B select: 00 = B, 01 = 4, 10 = signext, 11 = signext<<2
aluOp  out  3  ALU operation code
pcSrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump address, 11 = A
regDst  out  2  write-register select: 00 = rt, 01 = rd, 10 = 31
memToReg  out  2  write-data select: 00 = ALUOut, 01 = MDR, 10 = PC
regWrite  out  1  register-file write enable
illegal  out  1  one-cycle pulse on an unsupported opcode/func

Behaviour:
- State register updates on the rising edge of clk. When rst=0 at an edge, the next state is FETCH.
- Reset is synchronous: a reset mid-instruction abandons it.
- Every output is 0 in any cycle where rst=0. This gating is combinational on rst.
- Outputs are otherwise a pure function of state, except:
  - pcLd in BRANCH, which depends on zero;
  - memory-state enables, which depend on memReady.
- Unlisted outputs are 0 in each state.
- FETCH: iOrD=0, memRead=1, aluSrcA=0, aluSrcB=01, aluOp=ADD, pcSrc=00.
  - irWrite=pcLd=memReady.
  - If memReady=0, stay in FETCH; otherwise go to DECODE.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=ADD (branch target into ALUOut). Next state by opcode:
  - R-type → R_EXEC, or JR if func=001000
  - lw/sw → MEM_ADR
  - addi/slti → I_EXEC
  - beq → BRANCH
  - j → JUMP
  - jal → JAL
  - any other opcode/func → FETCH with illegal=1 for this cycle
- MEM_ADR: aluSrcA=1, aluSrcB=10, aluOp=ADD. Next is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: iOrD=1, memRead=1. Stall while memReady=0, then go to MEM_WB.
- MEM_WB: regDst=00, memToReg=01, regWrite=1. Next is FETCH.
- MEM_WRITE: iOrD=1, memWrite=1. Stall while memReady=0, then go to FETCH.
- R_EXEC: aluSrcA=1, aluSrcB=00, aluOp from func: add→ADD, sub→SUB, and→AND, or→OR, slt→SLT. Next is R_WB.
- R_WB: regDst=01, memToReg=00, regWrite=1. Next is FETCH.
- I_EXEC: aluSrcA=1, aluSrcB=10, aluOp=ADD for addi or SLT for slti. Next is I_WB.
- I_WB: regDst=00, memToReg=00, regWrite=1. Next is FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=SUB, pcSrc=01, pcLd=zero. Next is FETCH.
- JUMP: pcSrc=10, pcLd=1. Next is FETCH.
- JR: pcSrc=11, pcLd=1. Next is FETCH.
- JAL: pcSrc=10, pcLd=1, regDst=10, memToReg=10, regWrite=1. PC already holds PC+4 at this point. Next is FETCH.
- Cycles per instruction with memReady tied high:
  - lw 5; sw, R-type, addi, slti 4; beq, j, jal, jr 3.
  - Each memReady=0 cycle adds one cycle.
- memReady is ignored outside FETCH, MEM_READ and MEM_WRITE.
- Unreachable state encodings recover to FETCH on the next edge.

Decomposition:
- Package mips_mc_pkg holds:
  - state enum;
  - opcode constants: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, slti=001010, j=000010, jal=000011;
  - func constants: add=100000, sub=100010, and=100100, or=100101, slt=101010, jr=001000;
  - ALU codes: AND=000, OR=001, ADD=010, SUB=110, SLT=111;
  - mux-select encodings.
- Sub-module mc_alu_control: combinational func→aluOp decode plus a func-legal flag, instantiated once.

Test Plan:
- rst=0 for 2 edges, then rst=1 → all outputs 0 during reset. First post-reset cycle is FETCH: memRead=1, irWrite=1, pcLd=1, aluSrcB=01.
- add (opcode 000000, func 100000), memReady=1 → FETCH, DECODE, R_EXEC(aluOp=010), R_WB(regWrite=1, regDst=01), then FETCH on cycle 5.
- lw with memReady=0 for 2 cycles in MEM_READ → MEM_READ held 3 cycles with iOrD=1, memRead=1. Then MEM_WB with memToReg=01, regWrite=1; 7 cycles total.
- beq with zero=1, then zero=0 → BRANCH pcLd=1, pcSrc=01 in the first case; pcLd=0 in the second; both return to FETCH after 3 cycles.
- jal, then jr (opcode 0, func 001000) → JAL: regDst=10, memToReg=10, regWrite=1, pcSrc=10, pcLd=1. JR: pcSrc=11, pcLd=1, regWrite=0.
- Opcode 111111 → illegal=1 for exactly the DECODE cycle, next state FETCH. A second run with rst=0 asserted in MEM_ADR of an sw → memWrite never asserted; FETCH after reset is released.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller.
// Holds the FSM state enum, opcode/func constants, ALU operation codes,
// datapath mux-select encodings and the bundled control-word struct.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EXEC    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JR        = 4'd12,
    S_JAL       = 4'd13
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  // R-type func field (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Mux selects
  localparam logic       IORD_PC     = 1'b0;
  localparam logic       IORD_ALUOUT = 1'b1;
  localparam logic       SRCA_PC     = 1'b0;
  localparam logic       SRCA_REG    = 1'b1;
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // Full control word driven each cycle
  typedef struct packed {
    logic       pc_ld;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_alu_control.sv
// R-type func decoder.
// Ports:
//   func       in  6  IR[5:0]
//   alu_op     out 3  ALU operation for the ALU-type funcs (ADD when not legal)
//   func_legal out 1  func is one of add/sub/and/or/slt
// jr is intentionally not flagged legal here; the FSM recognises it itself
// because it routes to a different state rather than an ALU op.
module mc_alu_control
  import mips_mc_pkg::*;
(
  input  logic [5:0] func,
  output logic [2:0] alu_op,
  output logic       func_legal
);

  always_comb begin
    alu_op     = ALU_ADD;
    func_legal = 1'b1;
    case (func)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: func_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Moore-style control FSM for a multi-cycle MIPS datapath with a shared,
// possibly slow memory (memReady stalls FETCH / MEM_READ / MEM_WRITE).
// Ports:
//   clk, rst (sync, active-low)
//   opcode, func   IR fields
//   zero           ALU zero flag (qualifies pcLd in BRANCH)
//   memReady       memory completes current access this cycle
//   pcLd..illegal  datapath enables / mux selects; all forced 0 while rst=0
module mips_multicycle_controller
  import mips_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcLd,
  output logic       iOrD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] aluOp,
  output logic [1:0] pcSrc,
  output logic [1:0] regDst,
  output logic [1:0] memToReg,
  output logic       regWrite,
  output logic       illegal
);

  state_e     state_q, state_d;
  ctrl_t      c, ctrl;
  logic [2:0] fn_alu_op;
  logic       fn_legal;

  mc_alu_control u_alu_ctl (
    .func       (func),
    .alu_op     (fn_alu_op),
    .func_legal (fn_legal)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    c       = '0;
    case (state_q)
      S_FETCH: begin
        c.i_or_d    = IORD_PC;
        c.mem_read  = 1'b1;
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_src    = PCSRC_ALU;
        // IR and PC+4 only commit once the instruction word is actually back
        c.ir_write  = memReady;
        c.pc_ld     = memReady;
        state_d     = memReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_IMM_SH;
        c.alu_op    = ALU_ADD;
        case (opcode)
          OP_R: begin
            if (func == FN_JR) state_d = S_JR;
            else if (fn_legal) state_d = S_R_EXEC;
            else               c.illegal = 1'b1;
          end
          OP_LW, OP_SW:     state_d = S_MEM_ADR;
          OP_ADDI, OP_SLTI: state_d = S_I_EXEC;
          OP_BEQ:           state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_JAL:           state_d = S_JAL;
          default:          c.illegal = 1'b1;
        endcase
      end
      S_MEM_ADR: begin
        c.alu_src_a = SRCA_REG;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
        state_d     = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        c.i_or_d   = IORD_ALUOUT;
        c.mem_read = 1'b1;
        state_d    = memReady ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        c.reg_dst    = REGDST_RT;
        c.mem_to_reg = M2R_MDR;
        c.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        c.i_or_d    = IORD_ALUOUT;
        c.mem_write = 1'b1;
        state_d     = memReady ? S_FETCH : S_MEM_WRITE;
      end
      S_R_EXEC: begin
        c.alu_src_a = SRCA_REG;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = fn_alu_op;
        state_d     = S_R_WB;
      end
      S_R_WB: begin
        c.reg_dst    = REGDST_RD;
        c.mem_to_reg = M2R_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_I_EXEC: begin
        c.alu_src_a = SRCA_REG;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_d     = S_I_WB;
      end
      S_I_WB: begin
        c.reg_dst    = REGDST_RT;
        c.mem_to_reg = M2R_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = SRCA_REG;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALU_SUB;
        c.pc_src    = PCSRC_ALUOUT;
        c.pc_ld     = zero;
      end
      S_JUMP: begin
        c.pc_src = PCSRC_JUMP;
        c.pc_ld  = 1'b1;
      end
      S_JR: begin
        c.pc_src = PCSRC_REG;
        c.pc_ld  = 1'b1;
      end
      S_JAL: begin
        // PC already holds PC+4, so it is the link value written to $31
        c.pc_src     = PCSRC_JUMP;
        c.pc_ld      = 1'b1;
        c.reg_dst    = REGDST_RA;
        c.mem_to_reg = M2R_PC;
        c.reg_write  = 1'b1;
      end
      default: ; // unused encodings: all outputs 0, recover to FETCH
    endcase
  end

  // Outputs are killed combinationally while reset is held
  assign ctrl = rst ? c : '0;

  assign pcLd     = ctrl.pc_ld;
  assign iOrD     = ctrl.i_or_d;
  assign memRead  = ctrl.mem_read;
  assign memWrite = ctrl.mem_write;
  assign irWrite  = ctrl.ir_write;
  assign aluSrcA  = ctrl.alu_src_a;
  assign aluSrcB  = ctrl.alu_src_b;
  assign aluOp    = ctrl.alu_op;
  assign pcSrc    = ctrl.pc_src;
  assign regDst   = ctrl.reg_dst;
  assign memToReg = ctrl.mem_to_reg;
  assign regWrite = ctrl.reg_write;
  assign illegal  = ctrl.illegal;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Cycle-by-cycle vector bench for mips_multicycle_controller plus
// cycles-per-instruction sequences.
module tb_mips_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] func = 6'd0;
  logic       zero = 1'b0;
  logic       memReady = 1'b1;
  logic       pcLd, iOrD, memRead, memWrite, irWrite, aluSrcA, regWrite, illegal;
  logic [1:0] aluSrcB, pcSrc, regDst, memToReg;
  logic [2:0] aluOp;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mips_multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
    .memReady(memReady), .pcLd(pcLd), .iOrD(iOrD), .memRead(memRead),
    .memWrite(memWrite), .irWrite(irWrite), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSrc(pcSrc), .regDst(regDst),
    .memToReg(memToReg), .regWrite(regWrite), .illegal(illegal)
  );

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [18:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  // {pcLd,iOrD,memRead,memWrite,irWrite,aluSrcA,aluSrcB,aluOp,pcSrc,regDst,memToReg,regWrite,illegal}
  function automatic logic [18:0] o(input logic pl, iod, mr, mw, irw, sa,
                                    input logic [1:0] sb, input logic [2:0] op,
                                    input logic [1:0] ps, rd, m2r,
                                    input logic rw, ill);
    return {pl, iod, mr, mw, irw, sa, sb, op, ps, rd, m2r, rw, ill};
  endfunction

  function automatic logic [18:0] act_o();
    return {pcLd, iOrD, memRead, memWrite, irWrite, aluSrcA, aluSrcB, aluOp,
            pcSrc, regDst, memToReg, regWrite, illegal};
  endfunction

  task automatic add_v(input logic r, input logic [5:0] op, fn, input logic z, rdy,
                       input logic [18:0] e, input string nm);
    vec_t v;
    v.rst = r; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  // Starts in FETCH right after a negedge; runs one instruction with
  // memReady high and checks the cycles until the next FETCH.
  task automatic cpi(input logic [5:0] op, fn, input int want, input string nm);
    int  n;
    bit  done;
    rst = 1'b1; opcode = op; func = fn; zero = 1'b1; memReady = 1'b1;
    n = 0; done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(posedge clk); @(negedge clk); #1;
      n++;
      if (memRead && !iOrD) done = 1;
    end
    total++;
    if (!done || n != want) begin
      bad++;
      $display("FAIL cpi_%s: got %0d cycles (done=%0d) want %0d", nm, n, done, want);
    end
  endtask

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BEQ = 6'b000100, ADDI = 6'b001000, SLTI = 6'b001010,
                         J = 6'b000010, JAL = 6'b000011, BADOP = 6'b111111;
  localparam logic [5:0] FADD = 6'b100000, FSUB = 6'b100010, FAND = 6'b100100,
                         FOR = 6'b100101, FSLT = 6'b101010, FJR = 6'b001000,
                         BADFN = 6'b111111;

  logic [18:0] Z, F, FS, D, DI, MA, MR, MWB, MW, RWB, IWB, JO, JRO, JALO;

  function automatic logic [18:0] rex(input logic [2:0] op);
    return o(0,0,0,0,0,1,2'b00,op,2'b00,2'b00,2'b00,0,0);
  endfunction
  function automatic logic [18:0] iex(input logic [2:0] op);
    return o(0,0,0,0,0,1,2'b10,op,2'b00,2'b00,2'b00,0,0);
  endfunction
  function automatic logic [18:0] br(input logic z);
    return o(z,0,0,0,0,1,2'b00,3'b110,2'b01,2'b00,2'b00,0,0);
  endfunction

  task automatic r_instr(input logic [5:0] fn, input logic [2:0] aop, input logic rdy_ex,
                         input string nm);
    add_v(1, R, fn, 0, 1, F,         {nm, "_fetch"});
    add_v(1, R, fn, 0, 1, D,         {nm, "_decode"});
    add_v(1, R, fn, 0, rdy_ex, rex(aop), {nm, "_exec"});
    add_v(1, R, fn, 0, 1, RWB,       {nm, "_wb"});
  endtask

  initial begin
    Z    = '0;
    F    = o(1,0,1,0,1,0,2'b01,3'b010,2'b00,2'b00,2'b00,0,0);
    FS   = o(0,0,1,0,0,0,2'b01,3'b010,2'b00,2'b00,2'b00,0,0);
    D    = o(0,0,0,0,0,0,2'b11,3'b010,2'b00,2'b00,2'b00,0,0);
    DI   = o(0,0,0,0,0,0,2'b11,3'b010,2'b00,2'b00,2'b00,0,1);
    MA   = o(0,0,0,0,0,1,2'b10,3'b010,2'b00,2'b00,2'b00,0,0);
    MR   = o(0,1,1,0,0,0,2'b00,3'b000,2'b00,2'b00,2'b00,0,0);
    MWB  = o(0,0,0,0,0,0,2'b00,3'b000,2'b00,2'b00,2'b01,1,0);
    MW   = o(0,1,0,1,0,0,2'b00,3'b000,2'b00,2'b00,2'b00,0,0);
    RWB  = o(0,0,0,0,0,0,2'b00,3'b000,2'b00,2'b01,2'b00,1,0);
    IWB  = o(0,0,0,0,0,0,2'b00,3'b000,2'b00,2'b00,2'b00,1,0);
    JO   = o(1,0,0,0,0,0,2'b00,3'b000,2'b10,2'b00,2'b00,0,0);
    JRO  = o(1,0,0,0,0,0,2'b00,3'b000,2'b11,2'b00,2'b00,0,0);
    JALO = o(1,0,0,0,0,0,2'b00,3'b000,2'b10,2'b10,2'b10,1,0);

    // Reset held for two edges
    add_v(0, R, FADD, 0, 1, Z, "reset0");
    add_v(0, LW, FADD, 1, 1, Z, "reset1");
    // R-type family; 'and' execs with memReady low, which must be ignored
    r_instr(FADD, 3'b010, 1, "add");
    r_instr(FSUB, 3'b110, 1, "sub");
    r_instr(FAND, 3'b000, 0, "and");
    r_instr(FOR,  3'b001, 1, "or");
    r_instr(FSLT, 3'b111, 1, "slt");
    // lw with two MEM_READ stall cycles: 7 cycles
    add_v(1, LW, 0, 0, 1, F,   "lw_fetch");
    add_v(1, LW, 0, 0, 1, D,   "lw_decode");
    add_v(1, LW, 0, 0, 0, MA,  "lw_adr");
    add_v(1, LW, 0, 0, 0, MR,  "lw_rd_stall0");
    add_v(1, LW, 0, 0, 0, MR,  "lw_rd_stall1");
    add_v(1, LW, 0, 0, 1, MR,  "lw_rd_done");
    add_v(1, LW, 0, 0, 1, MWB, "lw_wb");
    // sw with a FETCH stall and a MEM_WRITE stall
    add_v(1, SW, 0, 0, 0, FS,  "sw_fetch_stall");
    add_v(1, SW, 0, 0, 1, F,   "sw_fetch");
    add_v(1, SW, 0, 0, 1, D,   "sw_decode");
    add_v(1, SW, 0, 0, 1, MA,  "sw_adr");
    add_v(1, SW, 0, 0, 0, MW,  "sw_wr_stall");
    add_v(1, SW, 0, 0, 1, MW,  "sw_wr_done");
    // I-type
    add_v(1, ADDI, 0, 0, 1, F,              "addi_fetch");
    add_v(1, ADDI, 0, 0, 1, D,              "addi_decode");
    add_v(1, ADDI, 0, 0, 1, iex(3'b010),    "addi_exec");
    add_v(1, ADDI, 0, 0, 1, IWB,            "addi_wb");
    add_v(1, SLTI, 0, 0, 1, F,              "slti_fetch");
    add_v(1, SLTI, 0, 0, 1, D,              "slti_decode");
    add_v(1, SLTI, 0, 0, 1, iex(3'b111),    "slti_exec");
    add_v(1, SLTI, 0, 0, 1, IWB,            "slti_wb");
    // beq taken / not taken
    add_v(1, BEQ, 0, 0, 1, F,      "beq1_fetch");
    add_v(1, BEQ, 0, 0, 1, D,      "beq1_decode");
    add_v(1, BEQ, 0, 1, 1, br(1),  "beq1_branch");
    add_v(1, BEQ, 0, 1, 1, F,      "beq0_fetch");
    add_v(1, BEQ, 0, 1, 1, D,      "beq0_decode");
    add_v(1, BEQ, 0, 0, 1, br(0),  "beq0_branch");
    // jumps
    add_v(1, J,   0,   0, 1, F,    "j_fetch");
    add_v(1, J,   0,   0, 1, D,    "j_decode");
    add_v(1, J,   0,   0, 1, JO,   "j_jump");
    add_v(1, JAL, 0,   0, 1, F,    "jal_fetch");
    add_v(1, JAL, 0,   0, 1, D,    "jal_decode");
    add_v(1, JAL, 0,   0, 1, JALO, "jal_jal");
    add_v(1, R,   FJR, 0, 1, F,    "jr_fetch");
    add_v(1, R,   FJR, 0, 1, D,    "jr_decode");
    add_v(1, R,   FJR, 0, 1, JRO,  "jr_jr");
    // illegal opcode / func: one-cycle pulse in DECODE then FETCH
    add_v(1, BADOP, 0,     0, 1, F,  "badop_fetch");
    add_v(1, BADOP, 0,     0, 1, DI, "badop_decode");
    add_v(1, R,     BADFN, 0, 1, F,  "badfn_fetch");
    add_v(1, R,     BADFN, 0, 1, DI, "badfn_decode");
    // reset during an illegal DECODE gates the pulse
    add_v(1, BADOP, 0,     0, 1, F,  "rstdec_fetch");
    add_v(0, BADOP, 0,     0, 1, Z,  "rstdec_decode");
    // reset during sw MEM_ADR abandons the store
    add_v(1, SW, 0, 0, 1, F,  "swrst_fetch");
    add_v(1, SW, 0, 0, 1, D,  "swrst_decode");
    add_v(0, SW, 0, 0, 1, Z,  "swrst_adr_reset");
    add_v(1, J,  0, 0, 1, F,  "swrst_refetch");
    add_v(1, J,  0, 0, 1, D,  "post_decode");
    add_v(1, J,  0, 0, 1, JO, "post_jump");

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; opcode = vecs[i].op; func = vecs[i].fn;
      zero = vecs[i].z; memReady = vecs[i].rdy;
      #1;
      total++;
      if (act_o() !== vecs[i].exp) begin
        bad++;
        $display("FAIL %s (vec %0d): got %b want %b", vecs[i].name, i, act_o(), vecs[i].exp);
      end
    end

    // Now in FETCH of a new instruction once the next negedge is reached
    @(negedge clk);
    cpi(LW,   0,    5, "lw");
    cpi(SW,   0,    4, "sw");
    cpi(R,    FADD, 4, "add");
    cpi(ADDI, 0,    4, "addi");
    cpi(SLTI, 0,    4, "slti");
    cpi(BEQ,  0,    3, "beq");
    cpi(J,    0,    3, "j");
    cpi(JAL,  0,    3, "jal");
    cpi(R,    FJR,  3, "jr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
